// File: rtl/regfile_sb.sv
// regfile_sb: 31 x 32-bit register file with a pending-result scoreboard and optional same-cycle write bypass
module regfile_sb #(
  parameter bit BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  input  logic        we,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        rsv_en,
  input  logic [4:0]  rsv_addr,
  output logic        rs_busy,
  output logic        rt_busy,
  output logic        stall,
  output logic [5:0]  pend_cnt
);
  // Entry 0 is never written and bit 0 of pend is never set, so index 0 reads as 0 and idle.
  logic [31:0] regs [32];
  logic [31:0] pend, set_v, clr_v;
  logic        wr_ok, rsv_ok, inc, dec, byp_rs, byp_rt;
  always_comb begin
    wr_ok   = we && wr_addr != '0;
    rsv_ok  = rsv_en && rsv_addr != '0;
    set_v   = rsv_ok ? 32'd1 << rsv_addr : '0;
    clr_v   = wr_ok ? 32'd1 << wr_addr : '0;
    inc     = rsv_ok && !pend[rsv_addr];
    dec     = wr_ok && pend[wr_addr] && !(rsv_ok && rsv_addr == wr_addr);
    byp_rs  = BYPASS && rst_n && wr_ok && wr_addr == rs_addr;
    byp_rt  = BYPASS && rst_n && wr_ok && wr_addr == rt_addr;
    rs_data = byp_rs ? wr_data : regs[rs_addr];
    rt_data = byp_rt ? wr_data : regs[rt_addr];
    rs_busy = pend[rs_addr] && !(BYPASS && we && wr_addr == rs_addr);
    rt_busy = pend[rt_addr] && !(BYPASS && we && wr_addr == rt_addr);
    stall   = rs_busy || rt_busy;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      if (wr_ok) regs[wr_addr] <= wr_data;
      pend     <= (pend & ~clr_v) | set_v;
      pend_cnt <= pend_cnt + 6'(inc) - 6'(dec);
    end
  end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter BYPASS, default 1: 1 = write-port data and pending-clear are visible to same-cycle reads; 0 = no bypass.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 rs_addr  input  5  read port A register index.
REQ-005 rt_addr  input  5  read port B register index.
REQ-006 rs_data  output  32  read port A data.
REQ-007 rt_data  output  32  read port B data.
REQ-008 we  input  1  write enable, sampled on the clk rising edge.
REQ-009 wr_addr  input  5  write register index.
REQ-010 wr_data  input  32  write data.
REQ-011 rsv_en  input  1  reserve request: marks rsv_addr pending (result outstanding).
REQ-012 rsv_addr  input  5  register index to reserve.
REQ-013 rs_busy  output  1  port A operand pending, not yet written.
REQ-014 rt_busy  output  1  port B operand pending, not yet written.
REQ-015 stall  output  1  rs_busy OR rt_busy.
REQ-016 pend_cnt  output  6  number of pending registers, range 0..31.

Function
REQ-017 Storage SHALL be 31 x 32-bit registers, indices 1..31; index 0 SHALL read 0 and is never pending.
REQ-018 On a clk rising edge with we=1 and wr_addr!=0, reg[wr_addr] SHALL take wr_data; wr_addr=0 writes SHALL be discarded.
REQ-019 Reads SHALL be combinational: rs_data=reg[rs_addr], rt_data=reg[rt_addr], 0 for index 0.
REQ-020 With BYPASS=1, if we=1, wr_addr!=0 and wr_addr equals a read index, that port SHALL return wr_data in the same cycle.
REQ-021 With BYPASS=0, a same-cycle write SHALL be visible on read ports only from the next cycle.
REQ-022 Pending bit pend[i] SHALL be set on a clk rising edge when rsv_en=1 and rsv_addr=i!=0.
REQ-023 pend[i] SHALL be cleared on a clk rising edge when we=1 and wr_addr=i, unless set in the same edge.
REQ-024 Simultaneous reserve and write of the same index: set SHALL win; pend[i]=1 and reg[i]=wr_data.
REQ-025 Reserving an already-pending index SHALL leave it pending; pend_cnt SHALL not double-count.
REQ-026 A write to a non-pending index SHALL update data and leave pend unchanged.
REQ-027 rs_busy SHALL be pend[rs_addr] AND NOT (BYPASS AND we AND wr_addr==rs_addr); rt_busy SHALL follow the same rule; both SHALL be 0 for index 0.
REQ-028 stall SHALL be combinational from rs_busy and rt_busy, with no register stage.
REQ-029 pend_cnt SHALL be registered and equal the population count of pend after each edge.
REQ-030 pend_cnt SHALL be updated per edge by +1, -1 or 0 from the net set/clear result and SHALL never wrap.

Reset
REQ-031 While rst_n=0, all registers and all pend bits SHALL be 0, and pend_cnt SHALL be 0, independent of clk.
REQ-032 During reset, outputs SHALL be rs_data=rt_data=0, rs_busy=rt_busy=stall=0.
REQ-033 Reset asserted mid-operation SHALL discard any same-cycle write or reserve.
REQ-034 The first edge after rst_n rises SHALL perform normal write and reserve operations.

Verification
REQ-035 Write then read with BYPASS=1:
- Stimulus: we=1, wr_addr=5, wr_data=0xDEADBEEF, rs_addr=5.
- Response: rs_data=0xDEADBEEF in the same cycle, and on every later cycle.
REQ-036 Register 0 write:
- Stimulus: we=1, wr_addr=0, wr_data=0xFFFFFFFF, then rs_addr=rt_addr=0.
- Response: rs_data=rt_data=0; pend_cnt unchanged.
REQ-037 Reserve then write:
- Stimulus: rsv_en=1, rsv_addr=7; next cycle rs_addr=7.
- Response: rs_busy=1, stall=1, pend_cnt=1.
- Stimulus: we=1, wr_addr=7.
- Response: rs_busy=0 in that cycle (BYPASS=1); pend_cnt=0 after the edge.
REQ-038 Simultaneous reserve and write:
- Stimulus: reg 3 pending; rsv_en=1, rsv_addr=3, we=1, wr_addr=3, wr_data=0x12 on one edge.
- Response: pend[3] stays 1, pend_cnt unchanged, rs_data(3)=0x12.
REQ-039 Full-scoreboard fill:
- Stimulus: reserve indices 1..31 on consecutive cycles, then reserve 0.
- Response: pend_cnt=31 and holds at 31.
REQ-040 Asynchronous reset:
- Stimulus: pend_cnt=4, reg 9=0xA5; assert rst_n=0 between clock edges.
- Response: pend_cnt=0, rs_data(9)=0 and stall=0 immediately, without waiting for a clk edge.
